// File: rtl/row_scan_sequencer.sv
// Row scanner for the LED matrix decoder: steps row_sel through 2^N rows with a dwell per row.
// Define SCAN_BLANKING_EN to insert a BLANK-cycle gap (row_ena low) before every row.
module row_scan_sequencer #(
  parameter int N     = 2,
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic [N-1:0] row_sel,
  output logic         row_ena,
  output logic         row_load,
  output logic         frame_start
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);

`ifdef SCAN_BLANKING_EN
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_DWELL} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row_sel     <= '0;
      row_ena     <= 1'b0;
      row_load    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      row_load    <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            cnt      <= '0;
            row_sel  <= '0;
            row_load <= 1'b1;
`ifdef SCAN_BLANKING_EN
            state    <= S_BLANK;
`else
            state       <= S_DWELL;
            row_ena     <= 1'b1;
            frame_start <= 1'b1;
`endif
          end
        end
`ifdef SCAN_BLANKING_EN
        S_BLANK: begin
          if (cnt == BL_LAST) begin
            state       <= S_DWELL;
            cnt         <= '0;
            row_ena     <= 1'b1;
            frame_start <= (row_sel == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_DWELL: begin
          if (cnt == DW_LAST) begin
            cnt <= '0;
            // run is only honoured here, so a row always completes its full slot
            if (run) begin
              row_sel  <= row_sel + 1'b1;
              row_load <= 1'b1;
`ifdef SCAN_BLANKING_EN
              state    <= S_BLANK;
              row_ena  <= 1'b0;
`else
              frame_start <= (row_sel == '1);
`endif
            end else begin
              state   <= S_IDLE;
              row_sel <= '0;
              row_ena <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Scoreboard bench for row_scan_sequencer (N=2, DWELL=3, BLANK=2); follows SCAN_BLANKING_EN if defined.
module tb_row_scan_sequencer;
  localparam int DW = 3;
`ifdef SCAN_BLANKING_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int SLOT = BL + DW;

  typedef struct packed {
    logic [1:0] sel;
    logic       ena;
    logic       load;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [1:0] row_sel;
  logic       row_ena, row_load, frame_start;

  int checks = 0;
  int failures = 0;
  int fs_seen = 0;
  exp_t expq[$];

  // reference model: position within a row slot
  bit m_act = 0;
  int m_row = 0;
  int m_pos = 0;

  row_scan_sequencer #(.N(2), .DWELL(DW), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .run(run), .row_sel(row_sel),
    .row_ena(row_ena), .row_load(row_load), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] dec(input logic [1:0] s, input logic e);
    dec = e ? (4'b0001 << s) : 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("row_sel", row_sel, e.sel);
      chk("row_ena", row_ena, e.ena);
      chk("row_load", row_load, e.load);
      chk("frame_start", frame_start, e.fs);
      chk("decoder_out", dec(row_sel, row_ena), dec(e.sel, e.ena));
      if (frame_start) fs_seen++;
    end
  end

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_row = 0; m_pos = 0;
    end else if (!m_act) begin
      if (run) begin m_act = 1; m_row = 0; m_pos = 0; end
    end else if (m_pos == SLOT - 1) begin
      if (run) begin m_row = (m_row + 1) % 4; m_pos = 0; end
      else begin m_act = 0; m_row = 0; m_pos = 0; end
    end else begin
      m_pos++;
    end
    e.sel  = m_act ? 2'(m_row) : 2'd0;
    e.ena  = m_act && (m_pos >= BL);
    e.load = m_act && (m_pos == 0);
    e.fs   = m_act && (m_row == 0) && (m_pos == BL);
    expq.push_back(e);
    #1;
  endtask

  task automatic wait_model(input int row, input int pos, input string name);
    int n = 0;
    while (!(m_act && m_row == row && m_pos == pos) && n < 100) begin
      cycle();
      n++;
    end
    chk({name, "_reached"}, int'(n < 100), 1);
  endtask

  initial begin
    int fs0;
    // reset held, then idle with run low
    repeat (3) cycle();
    rst = 1'b0;
    repeat (10) cycle();

    // continuous scan over two frames
    run = 1'b1;
    fs0 = fs_seen;
    repeat (40) cycle();
    #5;
    chk("frame_start_count", fs_seen - fs0, (BL > 0) ? 2 : 4);

    // drop run in the middle of row 2 dwell; the row must finish, then idle
    wait_model(2, BL + 1, "row2_dwell");
    run = 1'b0;
    repeat (SLOT + 6) cycle();
    #5;
    chk("idle_sel", row_sel, 0);
    chk("idle_ena", row_ena, 0);
    run = 1'b1;
    repeat (SLOT * 2 + 2) cycle();

    // async reset mid-dwell of row 1, between clock edges
    wait_model(1, BL + 1, "row1_dwell");
    #5;
    rst = 1'b1;
    #1;
    chk("async_rst_sel", row_sel, 0);
    chk("async_rst_ena", row_ena, 0);
    chk("async_rst_load", row_load, 0);
    chk("async_rst_fs", frame_start, 0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (SLOT * 5) cycle();
    run = 1'b0;
    repeat (SLOT + 3) cycle();
    #10;
    chk("queue_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
